onehot_enc: RTL and testbench

ONEHOT_ENC -- requirements
Module: onehot_enc

---
 rtl/onehot_enc_if.sv | 25 ++
 rtl/onehot_enc.sv | 128 ++++++++++++
 tb/tb_onehot_enc.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/onehot_enc_if.sv
// Stream interface for onehot_enc: request-vector input side and index output side.
interface onehot_enc_if #(
    parameter int WD  = 32,
    parameter int SEL = 5
);
    logic [WD-1:0]  in_vec;
    logic           in_valid;
    logic           in_ready;
    logic [SEL-1:0] out_idx;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic [SEL:0]   out_cnt;
    logic           zero_o;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_idx, out_valid, out_last, out_cnt, zero_o
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_idx, out_valid, out_last, out_cnt, zero_o
    );
endinterface

// File: rtl/onehot_enc.sv
// Captures a request vector and emits the index of each set bit in ascending order.
// Optional macro REG0_MASK_EN forces bit 0 of the captured vector to zero.
package my_pkg;
    localparam int DEF_WD  = 32;
    localparam int DEF_SEL = 5;
endpackage

module onehot_enc #(
    parameter int WD  = my_pkg::DEF_WD,
    parameter int SEL = my_pkg::DEF_SEL
) (
    input  logic        clk,
    input  logic        rst_n,
    onehot_enc_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t         state_r, state_nxt_s;
    logic [WD-1:0]  pending_r, pend_nxt_s, masked_s;
    logic [SEL-1:0] idx_r, idx_nxt_s;
    logic           last_r, last_nxt_s;
    logic [SEL:0]   cnt_r, cnt_nxt_s;
    logic           zero_r, zero_nxt_s;

    function automatic logic [SEL:0] popcount(input logic [WD-1:0] v);
        logic [SEL:0] c;
        c = {(SEL+1){1'b0}};
        for (int i = 0; i < WD; i++) begin
            c = c + {{SEL{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [SEL-1:0] lowest_idx(input logic [WD-1:0] v);
        logic [SEL-1:0] k;
        k = {SEL{1'b0}};
        for (int i = WD - 1; i >= 0; i--) begin
            if (v[i]) begin
                k = SEL'(i);
            end else begin
                k = k;
            end
        end
        return k;
    endfunction

    function automatic logic one_left(input logic [WD-1:0] v);
        return (v != {WD{1'b0}}) &&
               ((v & (v - {{(WD-1){1'b0}}, 1'b1})) == {WD{1'b0}});
    endfunction

    // Apply the optional register-0 mask to the incoming vector.
    always_comb begin
`ifdef REG0_MASK_EN
        masked_s = {bus.in_vec[WD-1:1], 1'b0};
`else
        masked_s = bus.in_vec;
`endif
    end

    // Next-state, next-pending and registered-output precomputation.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pending_r;
        cnt_nxt_s   = cnt_r;
        zero_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    pend_nxt_s = masked_s;
                    cnt_nxt_s  = popcount(masked_s);
                    if (masked_s != {WD{1'b0}}) begin
                        state_nxt_s = EMIT;
                    end else begin
                        zero_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                // Handshake retires the lowest set bit; in_valid is ignored here.
                if (bus.out_ready) begin
                    pend_nxt_s = pending_r & (pending_r - {{(WD-1){1'b0}}, 1'b1});
                    if (last_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = EMIT;
                    end
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pend_nxt_s  = {WD{1'b0}};
            end
        endcase
        idx_nxt_s  = lowest_idx(pend_nxt_s);
        last_nxt_s = one_left(pend_nxt_s);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pending_r <= {WD{1'b0}};
            idx_r     <= {SEL{1'b0}};
            last_r    <= 1'b0;
            cnt_r     <= {(SEL+1){1'b0}};
            zero_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pend_nxt_s;
            idx_r     <= idx_nxt_s;
            last_r    <= last_nxt_s;
            cnt_r     <= cnt_nxt_s;
            zero_r    <= zero_nxt_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == EMIT);
    assign bus.out_idx   = idx_r;
    assign bus.out_last  = last_r;
    assign bus.out_cnt   = cnt_r;
    assign bus.zero_o    = zero_r;
endmodule

// File: tb/tb_onehot_enc.sv
// Directed self-checking bench for onehot_enc with an expected-beat scoreboard.
module tb_onehot_enc;
    typedef struct packed {
        logic [4:0] idx;
        logic       last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    n_vec = 0;
    int    n_err = 0;
    beat_t sb[$];

    onehot_enc_if #(.WD(32), .SEL(5)) bus ();

    onehot_enc #(.WD(32), .SEL(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: push the expected beats for a vector, return the expected count.
    function automatic int build(input logic [31:0] vec);
        logic [31:0] v;
        int          hi;
        int          n;
        v = vec;
`ifdef REG0_MASK_EN
        v[0] = 1'b0;
`endif
        hi = -1;
        n  = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                hi = i;
                n++;
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (v[i]) sb.push_back('{idx: 5'(i), last: (i == hi)});
        end
        return n;
    endfunction

    task automatic run_vec(input logic [31:0] vec, input int stall,
                           input bit intrude, input logic [31:0] intr_vec);
        int    exp_cnt;
        beat_t e;
        check("ready_before", 32'(bus.in_ready), 32'd1);
        exp_cnt       = build(vec);
        bus.in_vec    = vec;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("cnt_load", 32'(bus.out_cnt), 32'(exp_cnt));
        if (exp_cnt == 0) begin
            check("zero_pulse", 32'(bus.zero_o), 32'd1);
            check("zero_novalid", 32'(bus.out_valid), 32'd0);
            check("zero_ready", 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            check("zero_end", 32'(bus.zero_o), 32'd0);
            check("zero_novalid2", 32'(bus.out_valid), 32'd0);
            return;
        end
        check("zero_quiet", 32'(bus.zero_o), 32'd0);
        for (int s = 0; s < stall; s++) begin
            e = sb[0];
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_idx", 32'(bus.out_idx), 32'(e.idx));
            check("stall_last", 32'(bus.out_last), 32'(e.last));
            bus.in_valid = intrude;
            bus.in_vec   = intr_vec;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("beat_valid", 32'(bus.out_valid), 32'd1);
            check("beat_idx", 32'(bus.out_idx), 32'(e.idx));
            check("beat_last", 32'(bus.out_last), 32'(e.last));
            check("beat_cnt", 32'(bus.out_cnt), 32'(exp_cnt));
            check("beat_busy", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        check("done_valid", 32'(bus.out_valid), 32'd0);
        check("done_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        beat_t e;
        int    n;
        bus.in_vec    = 32'h0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_idx", 32'(bus.out_idx), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        check("rst_cnt", 32'(bus.out_cnt), 32'd0);
        check("rst_zero", 32'(bus.zero_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(bus.in_ready), 32'd1);

        run_vec(32'h0000_0010, 0, 1'b0, 32'h0);
        run_vec(32'h8000_0005, 0, 1'b0, 32'h0);
        run_vec(32'h0000_0000, 0, 1'b0, 32'h0);
        run_vec(32'h0000_0300, 3, 1'b1, 32'h0000_00F0);
        run_vec(32'h0000_0001, 0, 1'b0, 32'h0);
        run_vec(32'hFFFF_FFFF, 0, 1'b0, 32'h0);
        run_vec(32'h0000_0006, 1, 1'b0, 32'h0);

        // Reset in the middle of a full-vector emission.
        n = build(32'hFFFF_FFFF);
        bus.in_vec    = 32'hFFFF_FFFF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rr_cnt", 32'(bus.out_cnt), 32'(n));
        for (int b = 0; b < 5; b++) begin
            e = sb.pop_front();
            check("rr_idx", 32'(bus.out_idx), 32'(e.idx));
            @(negedge clk);
        end
        check("rr_valid_pre", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_async_valid", 32'(bus.out_valid), 32'd0);
        check("rr_async_cnt", 32'(bus.out_cnt), 32'd0);
        check("rr_async_idx", 32'(bus.out_idx), 32'd0);
        check("rr_async_last", 32'(bus.out_last), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rr_post_valid", 32'(bus.out_valid), 32'd0);
            check("rr_post_ready", 32'(bus.in_ready), 32'd1);
        end

        run_vec(32'h8000_0000, 0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
